// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA text path: pixel/line counters, sync, active window,
// 9x16 character-cell coordinates and a frame-based cursor blink phase, all registered.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 720,
    parameter int unsigned H_FP       = 18,
    parameter int unsigned H_SYNC     = 108,
    parameter int unsigned H_BP       = 54,
    parameter int unsigned V_ACTIVE   = 400,
    parameter int unsigned V_FP       = 12,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 35,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter int unsigned CHAR_W     = 9,
    parameter int unsigned CHAR_H     = 16,
    parameter int unsigned BLINK_BITS = 5
) (
    input  logic       clk_pixel_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [9:0] h_cnt_o,
    output logic [8:0] v_cnt_o,
    output logic [6:0] col_o,
    output logic [4:0] row_o,
    output logic [3:0] glyph_x_o,
    output logic [3:0] glyph_y_o,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic       blink_o
);

    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] V_LAST  = 9'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG  = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END  = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0] GX_LAST = 4'(CHAR_W - 1);
    localparam logic [3:0] GY_LAST = 4'(CHAR_H - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [9:0]              h_q, h_d;
    logic [8:0]              v_q, v_d;
    logic [6:0]              col_q, col_d;
    logic [4:0]              row_q, row_d;
    logic [3:0]              gx_q, gx_d, gy_q, gy_d;
    logic [BLINK_BITS-1:0]   frame_q, frame_d;
    logic                    active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                    ls_q, ls_d, fs_q, fs_d, blink_q, blink_d;
    logic                    line_wrap;

    always_comb begin
        state_d   = ST_IDLE;
        h_d       = '0;
        v_d       = '0;
        col_d     = '0;
        row_d     = '0;
        gx_d      = '0;
        gy_d      = '0;
        frame_d   = frame_q;
        active_d  = 1'b0;
        hsync_d   = ~HSYNC_POL;
        vsync_d   = ~VSYNC_POL;
        ls_d      = 1'b0;
        fs_d      = 1'b0;
        blink_d   = 1'b0;
        line_wrap = 1'b0;
        if (en_i) begin
            state_d = ST_RUN;
            // Coming out of idle the counter defaults already give position (0,0).
            if (state_q == ST_RUN) begin
                if (h_q == H_LAST) begin
                    line_wrap = 1'b1;
                    if (v_q == V_LAST) begin
                        frame_d = frame_q + 1'b1;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                    v_d = v_q;
                end
            end
            if (h_d != '0 && h_d < H_ACT) begin
                if (gx_q == GX_LAST) begin
                    col_d = col_q + 1'b1;
                end else begin
                    gx_d  = gx_q + 1'b1;
                    col_d = col_q;
                end
            end
            // Cell rows only move on a line wrap into a visible line other than line 0.
            if (v_d != '0 && v_d < V_ACT) begin
                if (!line_wrap) begin
                    gy_d  = gy_q;
                    row_d = row_q;
                end else if (gy_q == GY_LAST) begin
                    row_d = row_q + 1'b1;
                end else begin
                    gy_d  = gy_q + 1'b1;
                    row_d = row_q;
                end
            end
            active_d = (h_d < H_ACT) && (v_d < V_ACT);
            hsync_d  = (h_d >= HS_BEG && h_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = (v_d >= VS_BEG && v_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            ls_d     = (h_d == '0);
            fs_d     = (h_d == '0) && (v_d == '0);
            blink_d  = frame_d[BLINK_BITS-1];
        end
    end

    always_ff @(posedge clk_pixel_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            frame_q  <= '0;
            active_q <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            col_q    <= col_d;
            row_q    <= row_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            frame_q  <= frame_d;
            active_q <= active_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
            blink_q  <= blink_d;
        end
    end

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign col_o         = col_q;
    assign row_o         = row_q;
    assign glyph_x_o     = gx_q;
    assign glyph_y_o     = gy_q;
    assign active_o      = active_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;
    assign blink_o       = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level detail and a shrunken instance
// for frame wrap, vertical decode and blink, both compared every cycle against a raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [8:0] v;
        logic [6:0] col;
        logic [4:0] row;
        logic [3:0] gx;
        logic [3:0] gy;
        logic       act, hs, vs, ls, fs, bl;
    } out_t;

    typedef struct packed {
        bit run;
        int h;
        int v;
        int f;
    } mst_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   checks = 0;
    int   errors = 0;
    int   t = 0;

    logic [9:0] d_h, s_h;
    logic [8:0] d_v, s_v;
    logic [6:0] d_col, s_col;
    logic [4:0] d_row, s_row;
    logic [3:0] d_gx, s_gx, d_gy, s_gy;
    logic d_act, d_hs, d_vs, d_ls, d_fs, d_bl;
    logic s_act, s_hs, s_vs, s_ls, s_fs, s_bl;
    out_t d_out, s_out;
    mst_t md = '0;
    mst_t ms = '0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk_pixel_i(clk), .rst_i(rst), .en_i(en),
        .h_cnt_o(d_h), .v_cnt_o(d_v), .col_o(d_col), .row_o(d_row),
        .glyph_x_o(d_gx), .glyph_y_o(d_gy), .active_o(d_act), .hsync_o(d_hs),
        .vsync_o(d_vs), .line_start_o(d_ls), .frame_start_o(d_fs), .blink_o(d_bl)
    );

    vga_timing_gen #(
        .H_ACTIVE(18), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
        .CHAR_W(9), .CHAR_H(16), .BLINK_BITS(2)
    ) dut_s (
        .clk_pixel_i(clk), .rst_i(rst), .en_i(en),
        .h_cnt_o(s_h), .v_cnt_o(s_v), .col_o(s_col), .row_o(s_row),
        .glyph_x_o(s_gx), .glyph_y_o(s_gy), .active_o(s_act), .hsync_o(s_hs),
        .vsync_o(s_vs), .line_start_o(s_ls), .frame_start_o(s_fs), .blink_o(s_bl)
    );

    assign d_out = {d_h, d_v, d_col, d_row, d_gx, d_gy, d_act, d_hs, d_vs, d_ls, d_fs, d_bl};
    assign s_out = {s_h, s_v, s_col, s_row, s_gx, s_gy, s_act, s_hs, s_vs, s_ls, s_fs, s_bl};

    // Raster position after one edge: row-major scan, frame count modulo 2^bb.
    function automatic mst_t step(mst_t s, logic e, int ht, int vt, int bb);
        mst_t n = s;
        if (!e) begin
            n.run = 1'b0;
        end else if (!s.run) begin
            n.run = 1'b1;
            n.h = 0;
            n.v = 0;
        end else begin
            n.h = s.h + 1;
            if (n.h == ht) begin
                n.h = 0;
                n.v = s.v + 1;
                if (n.v == vt) begin
                    n.v = 0;
                    n.f = (s.f + 1) % (1 << bb);
                end
            end
        end
        return n;
    endfunction

    function automatic out_t expect_out(mst_t s, int ha, int hf, int hsw, int va, int vf, int vsw,
                                        int cw, int ch, int bb, bit hp, bit vp);
        out_t o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        if (s.run) begin
            o.h   = 10'(s.h);
            o.v   = 9'(s.v);
            o.act = (s.h < ha) && (s.v < va);
            if (s.h < ha) begin
                o.col = 7'(s.h / cw);
                o.gx  = 4'(s.h % cw);
            end
            if (s.v < va) begin
                o.row = 5'(s.v / ch);
                o.gy  = 4'(s.v % ch);
            end
            o.hs = (s.h >= ha + hf && s.h < ha + hf + hsw) ? hp : ~hp;
            o.vs = (s.v >= va + vf && s.v < va + vf + vsw) ? vp : ~vp;
            o.ls = (s.h == 0);
            o.fs = (s.h == 0) && (s.v == 0);
            o.bl = 1'(((s.f >> (bb - 1)) & 1));
        end
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md <= '0;
            ms <= '0;
        end else begin
            md <= step(md, en, 900, 449, 5);
            ms <= step(ms, en, 25, 39, 2);
        end
    end

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic cycle_compare();
        out_t ed, es;
        ed = expect_out(md, 720, 18, 108, 400, 12, 2, 9, 16, 5, 1'b0, 1'b1);
        es = expect_out(ms, 18, 2, 3, 32, 2, 2, 9, 16, 2, 1'b1, 1'b0);
        checks += 2;
        if (d_out !== ed) begin
            errors++;
            $display("FAIL cycle_default actual=%h expected=%h (t=%0d)", d_out, ed, t);
        end
        if (s_out !== es) begin
            errors++;
            $display("FAIL cycle_small actual=%h expected=%h (t=%0d)", s_out, es, t);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_compare();
    endtask

    task automatic adv_to(int target);
        while (t < target) begin
            tick();
            t++;
        end
    endtask

    int hs_lo = 0, hs_first = -1, hs_last = -1;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        cmp("rst_h", int'(d_h), 0);
        cmp("rst_act", int'(d_act), 0);
        cmp("rst_hs_d", int'(d_hs), 1);
        cmp("rst_vs_d", int'(d_vs), 0);
        cmp("rst_hs_s", int'(s_hs), 0);
        cmp("rst_vs_s", int'(s_vs), 1);
        cmp("rst_fs", int'(d_fs), 0);
        rst = 1'b0;
        tick();
        cmp("first_h", int'(d_h), 0);
        cmp("first_act", int'(d_act), 1);
        cmp("first_fs", int'(d_fs), 1);
        cmp("first_ls", int'(d_ls), 1);
        cmp("first_hs", int'(d_hs), 1);
        cmp("first_vs", int'(d_vs), 0);

        for (int k = 0; k < 900; k++) begin
            if (k > 0) adv_to(k);
            if (d_hs == 1'b0) begin
                hs_lo++;
                if (hs_first < 0) hs_first = k;
                hs_last = k;
            end
            case (k)
                8:   begin cmp("h8_col", int'(d_col), 0);  cmp("h8_gx", int'(d_gx), 8); end
                9:   begin cmp("h9_col", int'(d_col), 1);  cmp("h9_gx", int'(d_gx), 0); end
                400: begin cmp("s_v16_row", int'(s_row), 1); cmp("s_v16_gy", int'(s_gy), 0);
                           cmp("s_v16_ls", int'(s_ls), 1); end
                719: begin cmp("h719_col", int'(d_col), 79); cmp("h719_gx", int'(d_gx), 8);
                           cmp("h719_act", int'(d_act), 1); end
                720: begin cmp("h720_col", int'(d_col), 0);  cmp("h720_gx", int'(d_gx), 0);
                           cmp("h720_act", int'(d_act), 0); end
                849: cmp("s_v33_vs", int'(s_vs), 1);
                850: cmp("s_v34_vs", int'(s_vs), 0);
                default: ;
            endcase
        end
        cmp("hs_width", hs_lo, 108);
        cmp("hs_first", hs_first, 738);
        cmp("hs_last", hs_last, 845);

        adv_to(900);
        cmp("wrap_h", int'(d_h), 0);
        cmp("wrap_v", int'(d_v), 1);
        cmp("wrap_ls", int'(d_ls), 1);
        cmp("wrap_fs", int'(d_fs), 0);
        adv_to(975);
        cmp("s_frame_fs", int'(s_fs), 1);
        cmp("s_frame_v", int'(s_v), 0);
        adv_to(1949);
        cmp("s_blink_pre", int'(s_bl), 0);
        adv_to(1950);
        cmp("s_blink_rise", int'(s_bl), 1);
        adv_to(3899);
        cmp("s_blink_hold", int'(s_bl), 1);
        adv_to(3900);
        cmp("s_blink_fall", int'(s_bl), 0);

        adv_to(45300);
        cmp("drop_h", int'(d_h), 300);
        cmp("drop_v", int'(d_v), 50);
        en = 1'b0;
        tick();
        cmp("idle_h", int'(d_h), 0);
        cmp("idle_v", int'(d_v), 0);
        cmp("idle_act", int'(d_act), 0);
        cmp("idle_hs", int'(d_hs), 1);
        cmp("idle_ls", int'(d_ls), 0);
        cmp("idle_blink_s", int'(s_bl), 0);
        tick();
        en = 1'b1;
        tick();
        cmp("reen_h", int'(d_h), 0);
        cmp("reen_v", int'(d_v), 0);
        cmp("reen_fs", int'(d_fs), 1);
        cmp("reen_ls", int'(d_ls), 1);
        cmp("reen_act", int'(d_act), 1);
        cmp("reen_blink_s", int'(s_bl), 1);

        for (int i = 0; i < 20; i++) begin
            en = 1'b1;
            repeat ($urandom_range(1, 1500)) tick();
            en = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
        end

        en = 1'b1;
        repeat ($urandom_range(50, 2000)) tick();
        #2 rst = 1'b1;
        #1;
        cmp("arst_h", int'(d_h), 0);
        cmp("arst_act", int'(d_act), 0);
        cmp("arst_hs_d", int'(d_hs), 1);
        cmp("arst_vs_s", int'(s_vs), 1);
        tick();
        rst = 1'b0;
        tick();
        cmp("arst_restart_fs", int'(d_fs), 1);
        cmp("arst_restart_bl", int'(s_bl), 0);
        repeat (2000) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
